fpnew_opgroup_rob_arbiter: RTL and testbench

//  In-order result collector for an operation group whose format slices have unequal latencies.

---
 rtl/fpnew_pkg.sv | 36 +++
 rtl/fpnew_rob_wb_decode.sv | 53 +++++
 rtl/fpnew_opgroup_rob_arbiter.sv | 171 +++++++++++++++++
 tb/tb_fpnew_opgroup_rob_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpnew_pkg.sv
// -----------------------------------------------------------------------------
// fpnew_pkg
// Shared types and helpers for the FP opgroup blocks.
//   status_t      : IEEE-754 exception flags returned with every result.
//   rob_ptr_full  : full test for a ROB whose head/tail pointers carry an
//                   extra wrap bit above the index bits.
// The ROB entry struct itself (rob_entry_t) is declared inside the arbiter,
// because its field widths follow that module's parameters.
// -----------------------------------------------------------------------------
package fpnew_pkg;

   typedef struct packed {
      logic NV; // invalid operation
      logic DZ; // divide by zero
      logic OF; // overflow
      logic UF; // underflow
      logic NX; // inexact
   } status_t;

   // Widest pointer rob_ptr_full can handle (index bits + wrap bit).
   localparam int unsigned ROB_PTR_MAX_W = 16;

   // Pointers are zero-extended to ROB_PTR_MAX_W by the caller. The ROB is
   // full when the index bits match and the wrap bits differ, i.e. the two
   // pointers differ in exactly the wrap bit.
   function automatic logic rob_ptr_full(
      input logic [ROB_PTR_MAX_W-1:0] head,
      input logic [ROB_PTR_MAX_W-1:0] tail,
      input int unsigned              id_width
   );
      logic [ROB_PTR_MAX_W-1:0] wrap_bit;
      wrap_bit = ROB_PTR_MAX_W'(1) << id_width;
      return ((head ^ tail) == wrap_bit);
   endfunction

endpackage

// File: rtl/fpnew_rob_wb_decode.sv
// -----------------------------------------------------------------------------
// fpnew_rob_wb_decode
// Turns the per-slice writeback strobes/IDs into a NumIn x Depth one-hot
// write-grant matrix and flags illegal writebacks.
//   i_valid  [NumIn]          per-slice writeback strobe
//   i_id     [NumIn*IdWidth]  per-slice target entry
//   i_alloc  [Depth]          entry is allocated
//   i_done   [Depth]          entry already holds its result
//   o_grant  [NumIn][Depth]   slice s writes entry d
//   o_err                     at least one strobe was dropped
// Per entry, the lowest-index slice targeting it "claims" it. The claim is
// granted only if the entry is allocated and not yet done; every other
// strobe (losing a same-ID race or aimed at an illegal entry) is dropped.
// -----------------------------------------------------------------------------
module fpnew_rob_wb_decode #(
   parameter int unsigned NumIn   = 2,
   parameter int unsigned Depth   = 4,
   parameter int unsigned IdWidth = 2
) (
   input  logic [NumIn-1:0]             i_valid,
   input  logic [NumIn*IdWidth-1:0]     i_id,
   input  logic [Depth-1:0]             i_alloc,
   input  logic [Depth-1:0]             i_done,
   output logic [NumIn-1:0][Depth-1:0]  o_grant,
   output logic                         o_err
);

   logic [Depth-1:0] w_claimed;

   always_comb begin
      o_grant   = '0;
      o_err     = 1'b0;
      w_claimed = '0;
      for (int d = 0; d < Depth; d++) begin
         for (int s = 0; s < NumIn; s++) begin
            if (i_valid[s] && (i_id[s*IdWidth +: IdWidth] == IdWidth'(d))) begin
               // Only the first claimant may write, and only a legal target.
               if (!w_claimed[d] && i_alloc[d] && !i_done[d]) begin
                  o_grant[s][d] = 1'b1;
               end
               w_claimed[d] = 1'b1;
            end
         end
      end
      // Any strobe that ended up without a grant was dropped.
      for (int s = 0; s < NumIn; s++) begin
         if (i_valid[s] && (o_grant[s] == '0)) begin
            o_err = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fpnew_opgroup_rob_arbiter.sv
// -----------------------------------------------------------------------------
// fpnew_opgroup_rob_arbiter
// In-order result collector for an opgroup whose format slices have unequal
// latencies. Each dispatched op reserves a ROB entry; slices write results
// back by entry ID in any order; results retire in dispatch order.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  synchronous flush, discards every entry
//   alloc_valid_i/ready_o    dispatch handshake; alloc_tag_i stored with op
//   alloc_id_o               entry ID handed to the slice with the op
//   wb_valid_i/id_i/result_i/status_i/ext_i   per-slice writeback (no backpressure)
//   out_valid_o/ready_i      retire handshake; result_o/status_o/
//                            extension_bit_o/tag_o come from the head entry
//   busy_o                   at least one entry allocated
//   wb_err_o                 one-cycle pulse after a dropped writeback
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and
// ready are both 1. valid never depends on ready; alloc_ready_o depends only
// on the full flag (a retire in the same cycle does not free a slot early);
// retire data holds steady while out_valid_o && !out_ready_i.
// -----------------------------------------------------------------------------
module fpnew_opgroup_rob_arbiter
   import fpnew_pkg::*;
#(
   parameter  int unsigned NumIn    = 2,
   parameter  int unsigned Width    = 32,
   parameter  int unsigned Depth    = 4,
   parameter  int unsigned TagWidth = 1,
   localparam int unsigned IdWidth  = $clog2(Depth)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic                       alloc_valid_i,
   output logic                       alloc_ready_o,
   input  logic [TagWidth-1:0]        alloc_tag_i,
   output logic [IdWidth-1:0]         alloc_id_o,
   input  logic [NumIn-1:0]           wb_valid_i,
   input  logic [NumIn*IdWidth-1:0]   wb_id_i,
   input  logic [NumIn*Width-1:0]     wb_result_i,
   input  logic [NumIn*5-1:0]         wb_status_i,
   input  logic [NumIn-1:0]           wb_ext_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [Width-1:0]           result_o,
   output logic [4:0]                 status_o,
   output logic                       extension_bit_o,
   output logic [TagWidth-1:0]        tag_o,
   output logic                       busy_o,
   output logic                       wb_err_o
);

   typedef struct packed {
      logic [Width-1:0]    result;
      status_t             status;
      logic                ext_bit;
      logic [TagWidth-1:0] tag;
   } rob_entry_t;

   localparam logic [IdWidth:0] PtrOne = {{IdWidth{1'b0}}, 1'b1};

   // Pointers carry one wrap bit above the index.
   logic [IdWidth:0]   r_head;
   logic [IdWidth:0]   r_tail;
   logic [Depth-1:0]   r_alloc;
   logic [Depth-1:0]   r_done;
   rob_entry_t         r_entry [Depth];
   logic               r_wb_err;

   logic [IdWidth-1:0]          w_head_idx;
   logic [IdWidth-1:0]          w_tail_idx;
   logic                        w_full;
   logic                        w_empty;
   logic                        w_alloc_fire;
   logic                        w_out_valid;
   logic                        w_pop;
   logic                        w_dec_err;
   logic [NumIn-1:0][Depth-1:0] w_grant;
   logic [Depth-1:0]            w_wr_en;
   rob_entry_t                  w_wr_data [Depth];

   assign w_head_idx   = r_head[IdWidth-1:0];
   assign w_tail_idx   = r_tail[IdWidth-1:0];
   assign w_empty      = (r_head == r_tail);
   assign w_full       = rob_ptr_full(ROB_PTR_MAX_W'(r_head), ROB_PTR_MAX_W'(r_tail), IdWidth);
   assign w_out_valid  = r_alloc[w_head_idx] & r_done[w_head_idx];
   assign w_alloc_fire = alloc_valid_i & ~w_full & ~flush_i;
   assign w_pop        = w_out_valid & out_ready_i & ~flush_i;

   fpnew_rob_wb_decode #(
      .NumIn   (NumIn),
      .Depth   (Depth),
      .IdWidth (IdWidth)
   ) u_wb_decode (
      .i_valid (wb_valid_i),
      .i_id    (wb_id_i),
      .i_alloc (r_alloc),
      .i_done  (r_done),
      .o_grant (w_grant),
      .o_err   (w_dec_err)
   );

   // Per-entry write data: at most one slice is granted per entry. The tag
   // field is left as stored at allocation.
   always_comb begin
      for (int d = 0; d < Depth; d++) begin
         w_wr_en[d]   = 1'b0;
         w_wr_data[d] = r_entry[d];
         for (int s = 0; s < NumIn; s++) begin
            if (w_grant[s][d]) begin
               w_wr_en[d]           = 1'b1;
               w_wr_data[d].result  = wb_result_i[s*Width +: Width];
               w_wr_data[d].status  = status_t'(wb_status_i[s*5 +: 5]);
               w_wr_data[d].ext_bit = wb_ext_i[s];
            end
         end
      end
   end

   // A granted writeback needs done=0 and alloc=1, so it never collides with
   // the retiring head (done=1) or the entry being allocated (alloc=0).
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_head   <= '0;
         r_tail   <= '0;
         r_alloc  <= '0;
         r_done   <= '0;
         r_wb_err <= 1'b0;
         for (int d = 0; d < Depth; d++) begin
            r_entry[d] <= '0;
         end
      end else if (flush_i) begin
         r_head   <= '0;
         r_tail   <= '0;
         r_alloc  <= '0;
         r_done   <= '0;
         r_wb_err <= 1'b0;
      end else begin
         r_wb_err <= w_dec_err;
         for (int d = 0; d < Depth; d++) begin
            if (w_wr_en[d]) begin
               r_entry[d] <= w_wr_data[d];
               r_done[d]  <= 1'b1;
            end
         end
         if (w_pop) begin
            r_alloc[w_head_idx] <= 1'b0;
            r_done[w_head_idx]  <= 1'b0;
            r_head              <= r_head + PtrOne;
         end
         if (w_alloc_fire) begin
            r_alloc[w_tail_idx]     <= 1'b1;
            r_done[w_tail_idx]      <= 1'b0;
            r_entry[w_tail_idx].tag <= alloc_tag_i;
            r_tail                  <= r_tail + PtrOne;
         end
      end
   end

   assign alloc_ready_o   = ~w_full;
   assign alloc_id_o      = w_tail_idx;
   assign out_valid_o     = w_out_valid;
   assign result_o        = r_entry[w_head_idx].result;
   assign status_o        = r_entry[w_head_idx].status;
   assign extension_bit_o = r_entry[w_head_idx].ext_bit;
   assign tag_o           = r_entry[w_head_idx].tag;
   assign busy_o          = ~w_empty;
   assign wb_err_o        = r_wb_err;

endmodule

// File: tb/tb_fpnew_opgroup_rob_arbiter.sv
module tb_fpnew_opgroup_rob_arbiter;
   localparam int NI = 2;
   localparam int W  = 32;
   localparam int D  = 4;
   localparam int TW = 4;
   localparam int IW = 2;
   localparam int EW = TW + 5 + 1 + W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic              alloc_valid = 1'b0;
   logic              alloc_ready_o;
   logic [TW-1:0]     alloc_tag = '0;
   logic [IW-1:0]     alloc_id_o;
   logic [NI-1:0]     wb_valid = '0;
   logic [NI*IW-1:0]  wb_id = '0;
   logic [NI*W-1:0]   wb_result = '0;
   logic [NI*5-1:0]   wb_status = '0;
   logic [NI-1:0]     wb_ext = '0;
   logic              out_valid_o;
   logic              out_ready = 1'b0;
   logic [W-1:0]      result_o;
   logic [4:0]        status_o;
   logic              extension_bit_o;
   logic [TW-1:0]     tag_o;
   logic              busy_o;
   logic              wb_err_o;

   // Scoreboard and model state
   int                n_checks = 0;
   int                n_pass = 0;
   logic [EW-1:0]     exp_q[$];
   logic [2:0]        m_tail = '0;
   logic [W-1:0]      m_res [D];
   logic [4:0]        m_st  [D];
   logic              m_ext [D];

   fpnew_opgroup_rob_arbiter #(
      .NumIn(NI), .Width(W), .Depth(D), .TagWidth(TW)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .flush_i         (flush),
      .alloc_valid_i   (alloc_valid),
      .alloc_ready_o   (alloc_ready_o),
      .alloc_tag_i     (alloc_tag),
      .alloc_id_o      (alloc_id_o),
      .wb_valid_i      (wb_valid),
      .wb_id_i         (wb_id),
      .wb_result_i     (wb_result),
      .wb_status_i     (wb_status),
      .wb_ext_i        (wb_ext),
      .out_valid_o     (out_valid_o),
      .out_ready_i     (out_ready),
      .result_o        (result_o),
      .status_o        (status_o),
      .extension_bit_o (extension_bit_o),
      .tag_o           (tag_o),
      .busy_o          (busy_o),
      .wb_err_o        (wb_err_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Retire monitor: sampled on the falling edge, the handshake completes on
   // the following rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid_o && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_retire", 64'(tag_o), 64'hDEAD);
         end else begin
            chk("retire_data", 64'({tag_o, status_o, extension_bit_o, result_o}),
                64'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_idle();
      wb_valid  = '0;
      wb_id     = '0;
      wb_result = '0;
      wb_status = '0;
      wb_ext    = '0;
   endtask

   task automatic do_alloc(input logic [TW-1:0] tag, output logic [IW-1:0] id);
      logic [IW-1:0] idx;
      idx = m_tail[IW-1:0];
      chk("alloc_ready", 64'(alloc_ready_o), 64'd1);
      chk("alloc_id", 64'(alloc_id_o), 64'(idx));
      m_res[idx] = $urandom;
      m_st[idx]  = 5'($urandom_range(0, 31));
      m_ext[idx] = 1'($urandom_range(0, 1));
      exp_q.push_back({tag, m_st[idx], m_ext[idx], m_res[idx]});
      alloc_valid = 1'b1;
      alloc_tag   = tag;
      tick();
      alloc_valid = 1'b0;
      m_tail      = m_tail + 3'd1;
      id          = idx;
   endtask

   // One slice writes one entry; bad=1 sends corrupted data (used for writes
   // that must be dropped).
   task automatic do_wb(input int s, input logic [IW-1:0] id, input logic bad);
      wb_idle();
      wb_valid[s]         = 1'b1;
      wb_id[s*IW +: IW]   = id;
      wb_result[s*W +: W] = bad ? ~m_res[id] : m_res[id];
      wb_status[s*5 +: 5] = bad ? ~m_st[id] : m_st[id];
      wb_ext[s]           = bad ? ~m_ext[id] : m_ext[id];
      tick();
      wb_idle();
   endtask

   // Slice 0 writes id_a, slice 1 writes id_b in the same cycle. With dup=1
   // slice 1 carries corrupted data that must lose.
   task automatic do_wb2(input logic [IW-1:0] id_a, input logic [IW-1:0] id_b, input logic dup);
      wb_valid              = 2'b11;
      wb_id                 = {id_b, id_a};
      wb_result[0 +: W]     = m_res[id_a];
      wb_status[0 +: 5]     = m_st[id_a];
      wb_ext[0]             = m_ext[id_a];
      wb_result[W +: W]     = dup ? ~m_res[id_b] : m_res[id_b];
      wb_status[5 +: 5]     = dup ? ~m_st[id_b] : m_st[id_b];
      wb_ext[1]             = dup ? ~m_ext[id_b] : m_ext[id_b];
      tick();
      wb_idle();
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      chk("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [IW-1:0] id;
      logic [IW-1:0] id_a;
      logic [IW-1:0] id_b;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_alloc_ready", 64'(alloc_ready_o), 64'd1);
      chk("rst_out_valid", 64'(out_valid_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_alloc_id", 64'(alloc_id_o), 64'd0);
      chk("rst_wb_err", 64'(wb_err_o), 64'd0);
      chk("rst_result", 64'(result_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Fill: IDs 0..3, then full
      for (int i = 0; i < 4; i++) do_alloc(TW'(i), id);
      chk("full_alloc_ready", 64'(alloc_ready_o), 64'd0);
      chk("full_busy", 64'(busy_o), 64'd1);
      do_wb(0, 2'd0, 1'b0);
      chk("head_valid", 64'(out_valid_o), 64'd1);

      // Full + pop + alloc in one cycle: pop only, ready rises next cycle
      out_ready   = 1'b1;
      alloc_valid = 1'b1;
      alloc_tag   = 4'hF;
      #1;
      chk("full_pop_ready", 64'(alloc_ready_o), 64'd0);
      tick();
      alloc_valid = 1'b0;
      out_ready   = 1'b0;
      chk("after_pop_ready", 64'(alloc_ready_o), 64'd1);
      chk("after_pop_valid", 64'(out_valid_o), 64'd0);
      do_alloc(4'h4, id);
      do_wb2(2'd1, 2'd2, 1'b0);
      chk("distinct_wb_err", 64'(wb_err_o), 64'd0);
      do_wb(1, 2'd3, 1'b0);
      do_wb(0, 2'd0, 1'b0);
      out_ready = 1'b1;
      wait_drain();
      chk("drain1_busy", 64'(busy_o), 64'd0);

      // Out-of-order completion: B first on slice 1, A three cycles later
      do_alloc(4'hA, id_a);
      do_alloc(4'hB, id_b);
      do_wb(1, id_b, 1'b0);
      chk("ab_wait_valid", 64'(out_valid_o), 64'd0);
      tick();
      tick();
      do_wb(0, id_a, 1'b0);
      chk("a_valid", 64'(out_valid_o), 64'd1);
      chk("a_tag", 64'(tag_o), 64'hA);
      tick();
      chk("b_valid", 64'(out_valid_o), 64'd1);
      chk("b_tag", 64'(tag_o), 64'hB);
      tick();
      chk("ab_busy", 64'(busy_o), 64'd0);
      out_ready = 1'b0;

      // Flush to realign pointers, then duplicate-ID and illegal writebacks
      flush = 1'b1;
      tick();
      flush  = 1'b0;
      m_tail = '0;
      chk("flush0_alloc_id", 64'(alloc_id_o), 64'd0);
      for (int i = 0; i < 3; i++) do_alloc(TW'(8 + i), id);
      do_wb2(2'd2, 2'd2, 1'b1);
      chk("dup_wb_err", 64'(wb_err_o), 64'd1);
      tick();
      chk("dup_wb_err_pulse", 64'(wb_err_o), 64'd0);
      do_wb(1, 2'd3, 1'b1);
      chk("free_wb_err", 64'(wb_err_o), 64'd1);
      chk("free_wb_valid", 64'(out_valid_o), 64'd0);
      do_wb(0, 2'd2, 1'b1);
      chk("done_wb_err", 64'(wb_err_o), 64'd1);
      do_wb2(2'd0, 2'd1, 1'b0);
      chk("legal_wb_err", 64'(wb_err_o), 64'd0);
      out_ready = 1'b1;
      wait_drain();
      chk("drain2_busy", 64'(busy_o), 64'd0);
      chk("drain2_valid", 64'(out_valid_o), 64'd0);

      // Wrap: ten allocate/retire pairs
      for (int i = 0; i < 10; i++) begin
         do_alloc(TW'(i), id);
         do_wb($urandom_range(0, 1), id, 1'b0);
         wait_drain();
      end
      chk("wrap_busy", 64'(busy_o), 64'd0);
      out_ready = 1'b0;

      // Flush with three pending entries, the middle one done
      do_alloc(4'h1, id_a);
      do_alloc(4'h2, id_b);
      do_alloc(4'h3, id);
      do_wb(0, id_b, 1'b0);
      chk("pre_flush_busy", 64'(busy_o), 64'd1);
      flush       = 1'b1;
      alloc_valid = 1'b1;
      tick();
      flush       = 1'b0;
      alloc_valid = 1'b0;
      exp_q.delete();
      m_tail = '0;
      chk("flush_busy", 64'(busy_o), 64'd0);
      chk("flush_valid", 64'(out_valid_o), 64'd0);
      chk("flush_alloc_id", 64'(alloc_id_o), 64'd0);
      chk("flush_alloc_ready", 64'(alloc_ready_o), 64'd1);

      // Asynchronous reset in the middle of operation
      do_alloc(4'h5, id_a);
      do_alloc(4'h6, id_b);
      do_wb(1, id_a, 1'b0);
      chk("pre_rst_valid", 64'(out_valid_o), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy_o), 64'd0);
      chk("arst_valid", 64'(out_valid_o), 64'd0);
      chk("arst_result", 64'(result_o), 64'd0);
      exp_q.delete();
      m_tail = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Recovery after reset
      out_ready = 1'b1;
      do_alloc(4'h7, id);
      do_wb(1, id, 1'b0);
      wait_drain();
      chk("final_busy", 64'(busy_o), 64'd0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
